// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and sizing for the write-back port arbiter.
//   wb_req_t : one buffered result {pd, ad, data}
//   rr_next  : modulo-NUM_REQ increment used by the rotate scan and rr pointer
package wb_port_arbiter_pkg;

  localparam int NUM_REQ       = 5;  // 0=add, 1=mul, 2=div, 3=mem, 4=br
  localparam int NUM_WB_PORTS  = 2;
  localparam int PHYS_REG_BITS = 6;
  localparam int ARCH_REG_BITS = 5;
  localparam int SRC_BITS      = $clog2(NUM_REQ);
  localparam int CNT_BITS      = $clog2(NUM_WB_PORTS + 1);
  localparam int PORT_BITS     = (NUM_WB_PORTS > 1) ? $clog2(NUM_WB_PORTS) : 1;

  typedef struct packed {
    logic [PHYS_REG_BITS-1:0] pd;
    logic [ARCH_REG_BITS-1:0] ad;
    logic [31:0]              data;
  } wb_req_t;

  // Both operands are below NUM_REQ, so a single conditional subtract wraps.
  function automatic logic [SRC_BITS-1:0] rr_next(input logic [SRC_BITS-1:0] idx,
                                                  input logic [SRC_BITS-1:0] step);
    logic [SRC_BITS:0] sum;
    sum = {1'b0, idx} + {1'b0, step};
    if (sum >= (SRC_BITS+1)'(NUM_REQ)) begin
      sum = sum - (SRC_BITS+1)'(NUM_REQ);
    end else begin
      sum = sum;
    end
    return sum[SRC_BITS-1:0];
  endfunction

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry valid/ready holding buffer for a single functional unit's result.
//   in_valid/in_ready/in_req : producer handshake and payload
//   grant                    : entry is written out this cycle (frees a slot for refill)
//   drop                     : entry is discarded this cycle without refill
//   flush                    : squash the entry and refuse new input
//   full/entry               : registered occupancy and payload
module wb_hold_buf
  import wb_port_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  logic    in_valid,
  output logic    in_ready,
  input  wb_req_t in_req,
  input  logic    grant,
  input  logic    drop,
  output logic    full,
  output wb_req_t entry
);

  logic    full_r;
  wb_req_t entry_r;

  // Only a port grant lets the slot be refilled in the same cycle; a dropped
  // pd==0 entry frees the slot on the following cycle.
  always_comb begin
    in_ready = rst_n && !flush && (!full_r || grant);
  end

  // Occupancy and payload register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r  <= 1'b0;
      entry_r <= '0;
    end else if (flush) begin
      full_r  <= 1'b0;
      entry_r <= entry_r;
    end else if (in_valid && in_ready) begin
      full_r  <= 1'b1;
      entry_r <= in_req;
    end else if (grant || drop) begin
      full_r  <= 1'b0;
      entry_r <= entry_r;
    end else begin
      full_r  <= full_r;
      entry_r <= entry_r;
    end
  end

  assign full  = full_r;
  assign entry = entry_r;

endmodule

// File: rtl/wb_port_arbiter_chk.sv
// Property checker for the write-back arbiter.
//   wb_we/wb_pd : port outputs; active ports must target distinct registers
//   grant/full  : per-requester grant and occupancy; never grant an empty buffer
module wb_port_arbiter_chk
  import wb_port_arbiter_pkg::*;
(
  input logic                                        clk,
  input logic                                        rst_n,
  input logic [NUM_WB_PORTS-1:0]                     wb_we,
  input logic [NUM_WB_PORTS-1:0][PHYS_REG_BITS-1:0]  wb_pd,
  input logic [NUM_REQ-1:0]                          grant,
  input logic [NUM_REQ-1:0]                          full
);

  for (genvar a = 0; a < NUM_WB_PORTS; a++) begin : g_a
    for (genvar b = a + 1; b < NUM_WB_PORTS; b++) begin : g_b
      a_pd_unique: assert property (@(posedge clk) disable iff (!rst_n)
        !(wb_we[a] && wb_we[b] && (wb_pd[a] == wb_pd[b])));
    end
  end

  a_grant_full: assert property (@(posedge clk) disable iff (!rst_n)
    ((grant & ~full) == '0));

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: NUM_REQ functional units share NUM_WB_PORTS
// register-file write ports through one-entry holding buffers and a
// round-robin rotate scan.
//   clk, rst_n, flush                : clock, async reset, mispredict squash
//   req_valid/req_ready/req_pd/ad/data : per-unit result handshake
//   wb_we/wb_pd/wb_ad/wb_data/wb_src   : per-port write enable, address, arch dest,
//                                       data (zeroed for ad==0) and granted unit
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
(
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        flush,
  input  logic [NUM_REQ-1:0]                          req_valid,
  output logic [NUM_REQ-1:0]                          req_ready,
  input  logic [NUM_REQ-1:0][PHYS_REG_BITS-1:0]       req_pd,
  input  logic [NUM_REQ-1:0][ARCH_REG_BITS-1:0]       req_ad,
  input  logic [NUM_REQ-1:0][31:0]                    req_data,
  output logic [NUM_WB_PORTS-1:0]                     wb_we,
  output logic [NUM_WB_PORTS-1:0][PHYS_REG_BITS-1:0]  wb_pd,
  output logic [NUM_WB_PORTS-1:0][ARCH_REG_BITS-1:0]  wb_ad,
  output logic [NUM_WB_PORTS-1:0][31:0]               wb_data,
  output logic [NUM_WB_PORTS-1:0][SRC_BITS-1:0]       wb_src
);

  logic [NUM_REQ-1:0]  full_s;
  logic [NUM_REQ-1:0]  elig_s;
  logic [NUM_REQ-1:0]  drop_s;
  logic [NUM_REQ-1:0]  grant_s;
  wb_req_t             req_in_s [NUM_REQ];
  wb_req_t             entry_s  [NUM_REQ];
  logic [SRC_BITS-1:0] rr_ptr_r;
  logic [SRC_BITS-1:0] last_s;
  logic [SRC_BITS-1:0] scan_idx_s;
  logic [CNT_BITS-1:0] n_grant_s;
  logic [PORT_BITS-1:0] port_s;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_buf
    assign req_in_s[gi] = '{pd: req_pd[gi], ad: req_ad[gi], data: req_data[gi]};
    // pd==0 results target the hardwired zero register: retire without a port.
    assign elig_s[gi]   = full_s[gi] && (entry_s[gi].pd != '0);
    assign drop_s[gi]   = full_s[gi] && (entry_s[gi].pd == '0);

    wb_hold_buf u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (req_valid[gi]),
      .in_ready (req_ready[gi]),
      .in_req   (req_in_s[gi]),
      .grant    (grant_s[gi]),
      .drop     (drop_s[gi]),
      .full     (full_s[gi]),
      .entry    (entry_s[gi])
    );
  end

  // Rotate scan from rr_ptr: the first eligible buffers fill ports 0.. in order.
  always_comb begin
    grant_s    = '0;
    wb_we      = '0;
    wb_pd      = '0;
    wb_ad      = '0;
    wb_data    = '0;
    wb_src     = '0;
    last_s     = rr_ptr_r;
    n_grant_s  = '0;
    scan_idx_s = rr_ptr_r;
    port_s     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx_s = rr_next(rr_ptr_r, SRC_BITS'(off));
      port_s     = n_grant_s[PORT_BITS-1:0];
      if (elig_s[scan_idx_s] && (n_grant_s < CNT_BITS'(NUM_WB_PORTS))) begin
        grant_s[scan_idx_s] = 1'b1;
        wb_we[port_s]       = 1'b1;
        wb_pd[port_s]       = entry_s[scan_idx_s].pd;
        wb_ad[port_s]       = entry_s[scan_idx_s].ad;
        // Writes to arch x0 carry zero so the ROB/RAT never sees a nonzero x0.
        wb_data[port_s]     = (entry_s[scan_idx_s].ad == '0) ? 32'h0000_0000
                                                             : entry_s[scan_idx_s].data;
        wb_src[port_s]      = scan_idx_s;
        last_s              = scan_idx_s;
        n_grant_s           = n_grant_s + CNT_BITS'(1);
      end else begin
        last_s = last_s;
      end
    end
  end

  // Round-robin pointer: resume just past the last unit served; flush does not stall it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (n_grant_s != '0) begin
      rr_ptr_r <= rr_next(last_s, SRC_BITS'(1));
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  wb_port_arbiter_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .wb_we (wb_we),
    .wb_pd (wb_pd),
    .grant (grant_s),
    .full  (full_s)
  );

endmodule
